// File: rtl/unary_add_seq.sv
// rtl/unary_add_seq.sv - sequencer driving an 8-bit unary adder core through clear, write and read phases
module unary_add_seq #(
  parameter int WIDTH       = 8,
  parameter int READ_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_sum,
  output logic             res_ovf,
  output logic             busy,
  output logic             add_rst_n,
  output logic             add_en,
  output logic             add_a,
  output logic             add_b,
  output logic             add_rw,
  input  logic             add_dout,
  input  logic             add_c
);

  // Read counter must hold READ_CYCLES-1 without wrapping.
  localparam int RCW = $clog2(READ_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WR_HI,
    S_WR_LO,
    S_READ,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [RCW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             add_rst_n_q, add_rst_n_d;
  logic             add_en_q, add_en_d;
  logic             add_a_q, add_a_d;
  logic             add_b_q, add_b_d;
  logic             add_rw_q, add_rw_d;
  logic [WIDTH:0]   idx_inc;

  // Index increment is one bit wider so n = 2**WIDTH-1 cannot wrap before the exit compare.
  assign idx_inc = {1'b0, idx_q} + {{WIDTH{1'b0}}, 1'b1};

  // Next-state logic; core drive values are derived from the next state so they register in step with it.
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    n_d         = n_q;
    idx_d       = idx_q;
    rd_cnt_d    = rd_cnt_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    add_rst_n_d = 1'b1;
    add_en_d    = 1'b0;
    add_a_d     = 1'b0;
    add_b_d     = 1'b0;
    add_rw_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_a_d  = op_a;
          op_b_d  = op_b;
          n_d     = (op_a > op_b) ? op_a : op_b;
          sum_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        ovf_d    = ovf_q | add_c;
        idx_d    = '0;
        rd_cnt_d = '0;
        state_d  = (n_q != '0) ? S_WR_HI : S_READ;
      end
      S_WR_HI: begin
        ovf_d   = ovf_q | add_c;
        state_d = S_WR_LO;
      end
      S_WR_LO: begin
        ovf_d   = ovf_q | add_c;
        idx_d   = idx_inc[WIDTH-1:0];
        state_d = (idx_inc < {1'b0, n_q}) ? S_WR_HI : S_READ;
      end
      S_READ: begin
        ovf_d    = ovf_q | add_c;
        rd_cnt_d = rd_cnt_q + RCW'(1);
        if (add_dout && (sum_q != '1)) begin
          sum_d = sum_q + {{WIDTH{1'b0}}, 1'b1};
        end
        if (rd_cnt_q == RCW'(READ_CYCLES - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_CLEAR: add_rst_n_d = 1'b0;
      S_WR_HI: begin
        add_en_d = 1'b1;
        add_a_d  = (idx_d < op_a_d);
        add_b_d  = (idx_d < op_b_d);
      end
      S_WR_LO: add_en_d = 1'b1;
      S_READ: begin
        add_en_d = 1'b1;
        add_rw_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, datapath and registered core drive, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      rd_cnt_q    <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      add_rst_n_q <= 1'b0;
      add_en_q    <= 1'b0;
      add_a_q     <= 1'b0;
      add_b_q     <= 1'b0;
      add_rw_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      rd_cnt_q    <= rd_cnt_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      add_rst_n_q <= add_rst_n_d;
      add_en_q    <= add_en_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_rw_q    <= add_rw_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res_sum   = sum_q;
  assign res_ovf   = ovf_q;
  assign add_rst_n = add_rst_n_q;
  assign add_en    = add_en_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_rw    = add_rw_q;

endmodule

// File: tb/tb_unary_add_seq.sv
// tb/tb_unary_add_seq.sv - self-checking bench for unary_add_seq with a behavioural unary adder core
module tb_unary_add_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [8:0] res_sum;
  logic       res_ovf;
  logic       busy;
  logic       add_rst_n, add_en, add_a, add_b, add_rw;
  logic       add_dout, add_c;

  always #5 clk = ~clk;

  unary_add_seq #(.WIDTH(8), .READ_CYCLES(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_ovf(res_ovf), .busy(busy),
    .add_rst_n(add_rst_n), .add_en(add_en), .add_a(add_a), .add_b(add_b),
    .add_rw(add_rw), .add_dout(add_dout), .add_c(add_c)
  );

  // Core model: counts A/B pulses in write mode, sticky carry on counter overflow,
  // in read mode emits one '1' on dout per counted unit.
  logic [7:0] m_cnt;
  logic       m_c;
  logic [8:0] m_rd;
  always_ff @(posedge clk or negedge add_rst_n) begin
    if (!add_rst_n) begin
      m_cnt <= '0;
      m_c   <= 1'b0;
      m_rd  <= '0;
    end else if (add_en) begin
      if (!add_rw) begin
        m_cnt <= m_cnt + 8'(add_a) + 8'(add_b);
        if (({1'b0, m_cnt} + 9'(add_a) + 9'(add_b)) > 9'd255) m_c <= 1'b1;
      end else begin
        m_rd <= m_rd + 9'd1;
      end
    end
  end
  assign add_dout = add_rw && (m_rd < {1'b0, m_cnt});
  assign add_c    = m_c;

  // Pulse monitor sampled on the falling edge.
  int   a_cnt = 0, b_cnt = 0, a_dbl = 0, b_dbl = 0, clr_cnt = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  always @(negedge clk) begin
    if (add_a) a_cnt++;
    if (add_b) b_cnt++;
    if (add_a && prev_a) a_dbl++;
    if (add_b && prev_b) b_dbl++;
    if (!add_rst_n) clr_cnt++;
    prev_a = add_a;
    prev_b = add_b;
  end

  typedef struct packed {
    logic [8:0] sum;
    logic       ovf;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] sum;
    logic       ovf;
    int         lat;
  } vec_t;
  vec_t vecs[6];

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [8:0] es,
                        input logic eo, input int el, input int hold);
    int   lat;
    int   ab, bb, ad, bd, cb;
    exp_t e;
    check("req_ready_idle", req_ready, 1);
    ab = a_cnt; bb = b_cnt; ad = a_dbl; bd = b_dbl; cb = clr_cnt;
    op_a = a; op_b = b; req_valid = 1'b1;
    sb_q.push_back({es, eo});
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    if (hold > 0) begin
      op_a = 8'd7; op_b = 8'd7; req_valid = 1'b1;
      check("req_ready_busy", req_ready, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat++;
    end
    while (!res_valid && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    check("res_valid_seen", res_valid, 1);
    check("latency", lat, el);
    for (int h = 0; h < hold; h++) begin
      check("hold_stable", {res_valid, res_sum, res_ovf, req_ready}, {1'b1, es, eo, 1'b0});
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check("res_sum", res_sum, e.sum);
      check("res_ovf", res_ovf, e.ovf);
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("res_valid_fall", res_valid, 0);
    check("busy_after", busy, 0);
    check("a_pulses", a_cnt - ab, a);
    check("b_pulses", b_cnt - bb, b);
    check("pulse_width", (a_dbl - ad) + (b_dbl - bd), 0);
    check("clear_cycles", clr_cnt - cb, 1);
  endtask

  initial begin
    int  k;
    logic seen;
    vecs[0] = '{8'd3,   8'd3,   9'd6,   1'b0, 264};
    vecs[1] = '{8'd5,   8'd0,   9'd5,   1'b0, 268};
    vecs[2] = '{8'd0,   8'd0,   9'd0,   1'b0, 258};
    vecs[3] = '{8'd255, 8'd255, 9'd254, 1'b1, 768};
    vecs[4] = '{8'd200, 8'd100, 9'd44,  1'b1, 658};
    vecs[5] = '{8'd1,   8'd2,   9'd3,   1'b0, 262};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_sum", res_sum, 0);
    check("rst_res_ovf", res_ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_add_rst_n", add_rst_n, 0);
    check("rst_add_drive", {add_en, add_a, add_b, add_rw}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_add_rst_n", add_rst_n, 1);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].ovf, vecs[i].lat, 0);
    end

    // Backpressure on the result plus a request while busy.
    run_op(8'd3, 8'd3, 9'd6, 1'b0, 264, 10);

    // Reset in the middle of the write phase aborts the operation.
    op_a = 8'd100; op_b = 8'd100; req_valid = 1'b1;
    sb_q.push_back({9'd200, 1'b0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (!add_a && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("wr_hi_reached", add_a, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_req_ready", req_ready, 1);
    check("abort_res_valid", res_valid, 0);
    check("abort_res_sum", res_sum, 0);
    check("abort_res_ovf", res_ovf, 0);
    check("abort_busy", busy, 0);
    check("abort_add_rst_n", add_rst_n, 0);
    check("abort_add_drive", {add_en, add_a, add_b, add_rw}, 0);
    sb_q.delete();
    seen = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (res_valid || busy) seen = 1'b1;
    end
    check("no_result_after_abort", seen, 0);
    run_op(8'd4, 8'd9, 9'd13, 1'b0, 276, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
